dvp_cam_tx: RTL and testbench

DVP_CAM_TX -- requirements
Module: dvp_cam_tx

---
 rtl/dvp_pkg.sv | 27 ++
 rtl/dvp_tx_timing.sv | 108 ++++++++++
 rtl/dvp_cam_tx.sv | 126 ++++++++++++
 tb/tb_dvp_cam_tx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP camera-bus transmitter: FSM state
// encoding, byte order on the bus and the bus idle levels.
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        HBLANK,
        VFRONT
    } dvp_state_e;

    localparam bit         HI_BYTE_FIRST  = 1'b1;
    localparam logic       DVP_VSYNC_IDLE = 1'b0;
    localparam logic       DVP_HREF_IDLE  = 1'b0;
    localparam logic [7:0] DVP_DAT_IDLE   = 8'h00;

    function automatic logic [7:0] first_byte(input logic [15:0] px);
        return HI_BYTE_FIRST ? px[15:8] : px[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] px);
        return HI_BYTE_FIRST ? px[7:0] : px[15:8];
    endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// Frame timing for the DVP transmitter: interval/line counters and the frame FSM.
// Exports the state the bus will show next cycle plus the take strobe and x/y of the pixel taken.
module dvp_tx_timing
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE     = 320,
    parameter int H_BLANK      = 144,
    parameter int V_ACTIVE     = 240,
    parameter int VSYNC_LINES  = 3,
    parameter int VBACK_LINES  = 17,
    parameter int VFRONT_LINES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output dvp_state_e  state_o,
    output dvp_state_e  state_nxt_o,
    output logic        take_o,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic        frame_start_o,
    output logic        frame_done_o
);

    localparam int L       = 2 * H_ACTIVE + H_BLANK;
    localparam int ACT_LEN = 2 * H_ACTIVE;
    localparam int VS_LEN  = VSYNC_LINES * L;
    localparam int VB_LEN  = VBACK_LINES * L;
    localparam int VF_LEN  = VFRONT_LINES * L;
    localparam int MAX_A   = (VS_LEN > VB_LEN) ? VS_LEN : VB_LEN;
    localparam int MAX_LEN = (MAX_A > VF_LEN) ? MAX_A : VF_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int LN_W    = $clog2(V_ACTIVE + 1);

    dvp_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LN_W-1:0]  line_q, line_d;
    logic             last_clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        line_d   = line_q;
        last_clk = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = VSYNC;
            end
            VSYNC: if (cnt_q == CNT_W'(VS_LEN - 1)) begin
                state_d = VBACK;
                cnt_d   = '0;
            end
            VBACK: if (cnt_q == CNT_W'(VB_LEN - 1)) begin
                state_d = ACTIVE;
                cnt_d   = '0;
                line_d  = '0;
            end
            ACTIVE: if (cnt_q == CNT_W'(ACT_LEN - 1)) begin
                state_d = HBLANK;
                cnt_d   = '0;
            end
            HBLANK: if (cnt_q == CNT_W'(H_BLANK - 1)) begin
                cnt_d = '0;
                if (line_q == LN_W'(V_ACTIVE - 1)) begin
                    state_d = VFRONT;
                    line_d  = '0;
                end else begin
                    state_d = ACTIVE;
                    line_d  = line_q + 1'b1;
                end
            end
            VFRONT: if (cnt_q == CNT_W'(VF_LEN - 1)) begin
                // enable is only sampled here, so a mid-frame drop never truncates
                last_clk = 1'b1;
                cnt_d    = '0;
                state_d  = enable ? VSYNC : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                line_d  = '0;
            end
        endcase
    end

    // Bus outputs are registered from the next state, so these describe the coming cycle.
    assign state_o       = state_q;
    assign state_nxt_o   = state_d;
    assign take_o        = (state_d == ACTIVE) && !cnt_d[0];
    assign x_o           = 16'(cnt_d >> 1);
    assign y_o           = 16'(line_d);
    assign frame_start_o = reset_n && (state_d == VSYNC) && (state_q != VSYNC);
    assign frame_done_o  = last_clk;

endmodule

// File: rtl/dvp_cam_tx.sv
// DVP camera-bus transmitter: one-pixel hold buffer, byte mux and sticky underrun.
// Optional macro DVP_CAM_TX_TEST_PATTERN_EN adds pat_en and an x/y pattern source.
module dvp_cam_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE     = 320,
    parameter int H_BLANK      = 144,
    parameter int V_ACTIVE     = 240,
    parameter int VSYNC_LINES  = 3,
    parameter int VBACK_LINES  = 17,
    parameter int VFRONT_LINES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    input  logic        underrun_clr,
`ifdef DVP_CAM_TX_TEST_PATTERN_EN
    input  logic        pat_en,
`endif
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_dat,
    output logic        frame_start,
    output logic        frame_done,
    output logic        underrun
);

    dvp_state_e  state_cur, state_nxt;
    logic        take, take_hold, pat_on, src_ok;
    logic [15:0] x_idx, y_idx, src_px;
    logic        unused_sink;

    logic [15:0] hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  lo_q, lo_d, dat_q, dat_d;
    logic        vsync_q, href_q, underrun_q, underrun_d;

    dvp_tx_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .H_BLANK     (H_BLANK),
        .V_ACTIVE    (V_ACTIVE),
        .VSYNC_LINES (VSYNC_LINES),
        .VBACK_LINES (VBACK_LINES),
        .VFRONT_LINES(VFRONT_LINES)
    ) u_timing (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .state_o      (state_cur),
        .state_nxt_o  (state_nxt),
        .take_o       (take),
        .x_o          (x_idx),
        .y_o          (y_idx),
        .frame_start_o(frame_start),
        .frame_done_o (frame_done)
    );

`ifdef DVP_CAM_TX_TEST_PATTERN_EN
    assign pat_on      = pat_en;
    assign src_px      = pat_en ? {x_idx[7:0], y_idx[7:0]} : hold_q;
    assign src_ok      = pat_en | hold_valid_q;
    assign unused_sink = ^{state_cur, x_idx[15:8], y_idx[15:8]};
`else
    assign pat_on      = 1'b0;
    assign src_px      = hold_q;
    assign src_ok      = hold_valid_q;
    assign unused_sink = ^{state_cur, x_idx, y_idx};
`endif

    // The pattern generator never drains the hold register, so it keeps its pixel for later.
    assign take_hold = take & ~pat_on;
    assign pix_ready = ~pat_on & (~hold_valid_q | take_hold);

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        lo_d         = lo_q;
        dat_d        = DVP_DAT_IDLE;
        underrun_d   = underrun_q & ~underrun_clr;
        if (take_hold) hold_valid_d = 1'b0;
        if (pix_valid && pix_ready) begin
            hold_d       = pix_data;
            hold_valid_d = 1'b1;
        end
        if (take) begin
            if (src_ok) begin
                dat_d = first_byte(src_px);
                lo_d  = second_byte(src_px);
            end else begin
                lo_d       = DVP_DAT_IDLE;
                underrun_d = 1'b1;
            end
        end else if (state_nxt == ACTIVE) begin
            dat_d = lo_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            lo_q         <= DVP_DAT_IDLE;
            dat_q        <= DVP_DAT_IDLE;
            vsync_q      <= DVP_VSYNC_IDLE;
            href_q       <= DVP_HREF_IDLE;
            underrun_q   <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            lo_q         <= lo_d;
            dat_q        <= dat_d;
            vsync_q      <= (state_nxt == VSYNC);
            href_q       <= (state_nxt == ACTIVE);
            underrun_q   <= underrun_d;
        end
    end

    assign cam_vsync = vsync_q;
    assign cam_href  = href_q;
    assign cam_dat   = dat_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Randomized bench for dvp_cam_tx against a frame-position reference model.
module tb_dvp_cam_tx;

    localparam int HA      = 4;
    localparam int HB      = 4;
    localparam int VA      = 3;
    localparam int NL      = 1;
    localparam int L       = 2 * HA + HB;
    localparam int VS_END  = NL * L;
    localparam int ACT_BEG = VS_END + NL * L;
    localparam int ACT_END = ACT_BEG + VA * L;
    localparam int FRAME   = ACT_END + NL * L;

    logic        clk = 1'b0;
    logic        reset_n, enable, pix_valid, underrun_clr;
    logic [15:0] pix_data;
    logic        pix_ready, cam_vsync, cam_href, frame_start, frame_done, underrun;
    logic [7:0]  cam_dat;
`ifdef DVP_CAM_TX_TEST_PATTERN_EN
    logic        pat_en = 1'b0;
`endif

    always #5 clk = ~clk;

    dvp_cam_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(NL), .VBACK_LINES(NL), .VFRONT_LINES(NL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underrun_clr(underrun_clr),
`ifdef DVP_CAM_TX_TEST_PATTERN_EN
        .pat_en      (pat_en),
`endif
        .pix_ready   (pix_ready),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_dat     (cam_dat),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: frame position plus a one-deep pixel store.
    bit          m_run, m_occ, m_cur_ok, m_unr;
    int          m_pos;
    logic [15:0] m_hold, m_cur;
    logic [15:0] dirq[$];
    logic [7:0]  recq[$];
    int          rec_line = -2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit m_href(input bit run, input int pos);
        return run && pos >= ACT_BEG && pos < ACT_END && ((pos - ACT_BEG) % L) < 2 * HA;
    endfunction

    function automatic logic [15:0] next_px();
        if (dirq.size() > 0) return dirq.pop_front();
        return 16'($urandom);
    endfunction

    function automatic bit pat_mode();
`ifdef DVP_CAM_TX_TEST_PATTERN_EN
        return pat_en;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: check this cycle's outputs, then advance the model across the edge.
    task automatic step();
        bit nrun, tk, rdy_e, acc, unr_set, pm;
        int npos, h, ln;
        logic [7:0] dat_e;
        #1;
        pm = pat_mode();
        if (!m_run || m_pos == FRAME - 1) begin
            nrun = enable;
            npos = 0;
        end else begin
            nrun = 1'b1;
            npos = m_pos + 1;
        end
        tk    = m_href(nrun, npos) && ((((npos - ACT_BEG) % L) % 2) == 0);
        rdy_e = !pm && (!m_occ || tk);
        dat_e = 8'h00;
        if (m_href(m_run, m_pos) && m_cur_ok) begin
            h     = (m_pos - ACT_BEG) % L;
            dat_e = (h % 2 == 0) ? m_cur[15:8] : m_cur[7:0];
        end
        chk("pix_ready", pix_ready, rdy_e);
        chk("vsync", cam_vsync, m_run && m_pos < VS_END);
        chk("href", cam_href, m_href(m_run, m_pos));
        chk("dat", cam_dat, dat_e);
        chk("frame_start", frame_start, enable && (!m_run || m_pos == FRAME - 1));
        chk("frame_done", frame_done, m_run && m_pos == FRAME - 1);
        chk("underrun", underrun, m_unr);
        if (rec_line != -2 && m_href(m_run, m_pos)) begin
            h  = (m_pos - ACT_BEG) % L;
            ln = (m_pos - ACT_BEG) / L;
            if ((rec_line < 0 || ln == rec_line) && (recq.size() > 0 || h == 0))
                recq.push_back(cam_dat);
        end
        acc = pix_valid && rdy_e;
        @(posedge clk);
        #1;
        unr_set = 1'b0;
        if (tk) begin
            if (pm) begin
                h        = ((npos - ACT_BEG) % L) / 2;
                ln       = (npos - ACT_BEG) / L;
                m_cur    = {h[7:0], ln[7:0]};
                m_cur_ok = 1'b1;
            end else if (m_occ) begin
                m_cur    = m_hold;
                m_cur_ok = 1'b1;
                m_occ    = 1'b0;
            end else begin
                m_cur_ok = 1'b0;
                unr_set  = 1'b1;
            end
        end
        m_unr = unr_set ? 1'b1 : (underrun_clr ? 1'b0 : m_unr);
        if (acc) begin
            m_hold   = pix_data;
            m_occ    = 1'b1;
            pix_data = next_px();
        end
        m_run = nrun;
        m_pos = npos;
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_pos    = 0;
        m_occ    = 1'b0;
        m_cur_ok = 1'b0;
        m_unr    = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_vsync"}, cam_vsync, 1'b0);
        chk({tag, "_href"}, cam_href, 1'b0);
        chk({tag, "_dat"}, cam_dat, 8'h00);
        chk({tag, "_fstart"}, frame_start, 1'b0);
        chk({tag, "_fdone"}, frame_done, 1'b0);
        chk({tag, "_underrun"}, underrun, 1'b0);
        chk({tag, "_ready"}, pix_ready, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        reset_checks("midrst");
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    logic [7:0] exp_seq [4] = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    logic [7:0] exp_pat [8] = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h02};

    initial begin
        bit dropped;
        int idle_n;
        reset_n      = 1'b1;
        enable       = 1'b1;
        pix_valid    = 1'b0;
        underrun_clr = 1'b0;
        dirq         = '{16'h1234, 16'hABCD};
        pix_data     = next_px();
        model_reset();
        m_hold = '0;
        m_cur  = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("rst");
        #1 reset_n = 1'b1;

        // Two back-to-back frames with a continuous pixel supply.
        recq.delete();
        rec_line = -1;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            enable = 1'b1; pix_valid = 1'b1; underrun_clr = 1'b0;
            step();
        end
        rec_line = -2;
        for (int k = 0; k < 4; k++)
            chk($sformatf("seq%0d", k), (recq.size() > k) ? recq[k] : 8'hxx, exp_seq[k]);

        // Starve the second pixel of line 1.
        for (int i = 0; i < FRAME; i++) begin
            enable = 1'b1; underrun_clr = 1'b0;
            pix_valid = !(m_run && m_pos >= ACT_BEG - 1 && m_pos <= ACT_BEG + 1);
            step();
        end
        chk("underrun_sticky", underrun, 1'b1);

        // Clear coinciding with a new underrun, then a lone clear.
        for (int i = 0; i < FRAME; i++) begin
            enable = 1'b1;
            pix_valid = !(m_run && m_pos >= ACT_BEG - 1 && m_pos <= ACT_BEG + 1);
            underrun_clr = m_run && (m_pos == ACT_BEG + 1 || m_pos == ACT_END + 2);
            step();
        end

        // Reset in the middle of line 2.
        for (int i = 0; i < 3 * FRAME; i++) begin
            enable = 1'b1; pix_valid = 1'b1; underrun_clr = 1'b0;
            step();
            if (m_href(m_run, m_pos) && m_pos >= ACT_BEG + L) begin
                do_reset();
                break;
            end
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            enable       = ($urandom_range(0, 99) < 90);
            pix_valid    = ($urandom_range(0, 99) < 80);
            underrun_clr = ($urandom_range(0, 99) < 4);
            step();
        end

`ifdef DVP_CAM_TX_TEST_PATTERN_EN
        pat_en = 1'b1;
        recq.delete();
        for (int i = 0; i < 3 * FRAME; i++) begin
            enable = 1'b1; pix_valid = 1'($urandom_range(0, 1)); underrun_clr = 1'b0;
            step();
            if (i == 1) rec_line = 2;
            if (recq.size() >= 8) break;
        end
        rec_line = -2;
        chk("pat_len", recq.size(), 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("pat%0d", k), (recq.size() > k) ? recq[k] : 8'hxx, exp_pat[k]);
        pat_en = 1'b0;
`endif

        // Drop enable during line 2; the frame must finish and the FSM go idle.
        dropped = 1'b0;
        idle_n  = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m_run && m_pos >= ACT_BEG + L && m_pos < ACT_BEG + 2 * L) dropped = 1'b1;
            enable = !dropped; pix_valid = 1'b1; underrun_clr = 1'b0;
            step();
            if (dropped && !m_run) idle_n++;
            if (idle_n >= 10) break;
        end
        chk("drop_reached_idle", idle_n, 10);
        chk("drop_vsync_idle", cam_vsync, 1'b0);
        chk("drop_href_idle", cam_href, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
